// File: rtl/coprocessor_0.sv
// CP0 register file: MFC0/MTC0 responder, Count/Compare timer, interrupt pending
// logic, and exception-entry / ERET bookkeeping.
module coprocessor_0 #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] PRID       = 32'h0001_8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  cp0_reg_rw,
    input  logic [4:0]            cp0_reg_read_addr,
    output logic [DATA_WIDTH-1:0] cp0_reg_read,
    input  logic [4:0]            cp0_reg_write_addr,
    input  logic [DATA_WIDTH-1:0] cp0_reg_write,
    input  logic [5:0]            hw_int,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  exc_in_delay_slot,
    input  logic [DATA_WIDTH-1:0] exc_badvaddr,
    input  logic                  eret,
    output logic [DATA_WIDTH-1:0] epc,
    output logic [DATA_WIDTH-1:0] status,
    output logic [DATA_WIDTH-1:0] cause,
    output logic                  timer_int,
    output logic                  int_req
);
    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    logic [DATA_WIDTH-1:0] badvaddr_reg, count_reg, compare_reg, epc_reg;
    logic [7:0]            im_reg;
    logic                  exl_reg, ie_reg;
    logic                  bd_reg;
    logic [4:0]            exc_code_reg;
    logic [1:0]            ip_sw_reg;
    logic [5:0]            ip_hw_reg;
    logic                  toggle_reg, timer_int_reg;
    logic                  wr_en;

    assign wr_en = cp0_reg_rw && !stall;

    // BEV is hard-wired to 1; only IM/EXL/IE are stored.
    assign status = {9'b0, 1'b1, 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
    // IP[7] sees timer_int directly so int_req follows it without an extra cycle.
    assign cause  = {bd_reg, timer_int_reg, 14'b0, ip_hw_reg[5] | timer_int_reg,
                     ip_hw_reg[4:0], ip_sw_reg, 1'b0, exc_code_reg, 2'b0};
    assign epc       = epc_reg;
    assign timer_int = timer_int_reg;
    assign int_req   = (|(cause[15:8] & im_reg)) & ie_reg & ~exl_reg;

    always_comb begin
        cp0_reg_read = '0;
        case (cp0_reg_read_addr)
            ADDR_BADVADDR: cp0_reg_read = badvaddr_reg;
            ADDR_COUNT:    cp0_reg_read = count_reg;
            ADDR_COMPARE:  cp0_reg_read = compare_reg;
            ADDR_STATUS:   cp0_reg_read = status;
            ADDR_CAUSE:    cp0_reg_read = cause;
            ADDR_EPC:      cp0_reg_read = epc_reg;
            ADDR_PRID:     cp0_reg_read = PRID;
            default:       cp0_reg_read = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr_reg  <= '0;
            count_reg     <= '0;
            compare_reg   <= 32'hFFFF_FFFF;
            epc_reg       <= '0;
            im_reg        <= '0;
            exl_reg       <= 1'b0;
            ie_reg        <= 1'b0;
            bd_reg        <= 1'b0;
            exc_code_reg  <= '0;
            ip_sw_reg     <= '0;
            ip_hw_reg     <= '0;
            toggle_reg    <= 1'b0;
            timer_int_reg <= 1'b0;
        end else begin
            ip_hw_reg <= hw_int;

            // Count advances every second clock and ignores stall.
            if (wr_en && cp0_reg_write_addr == ADDR_COUNT) begin
                count_reg  <= cp0_reg_write;
                toggle_reg <= 1'b0;
            end else begin
                toggle_reg <= ~toggle_reg;
                if (toggle_reg)
                    count_reg <= count_reg + 1'b1;
            end

            if (wr_en && cp0_reg_write_addr == ADDR_COMPARE) begin
                compare_reg   <= cp0_reg_write;
                timer_int_reg <= 1'b0;
            end else if (count_reg == compare_reg) begin
                timer_int_reg <= 1'b1;
            end

            if (wr_en && cp0_reg_write_addr == ADDR_STATUS) begin
                im_reg <= cp0_reg_write[15:8];
                ie_reg <= cp0_reg_write[0];
            end

            if (exc_valid)
                exl_reg <= 1'b1;
            else if (eret)
                exl_reg <= 1'b0;
            else if (wr_en && cp0_reg_write_addr == ADDR_STATUS)
                exl_reg <= cp0_reg_write[1];

            if (wr_en && cp0_reg_write_addr == ADDR_CAUSE)
                ip_sw_reg <= cp0_reg_write[9:8];

            // Nested exceptions keep the original EPC/BD.
            if (exc_valid) begin
                exc_code_reg <= exc_code;
                if (!exl_reg) begin
                    epc_reg <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    bd_reg  <= exc_in_delay_slot;
                end
                if (exc_code == 5'd4 || exc_code == 5'd5)
                    badvaddr_reg <= exc_badvaddr;
            end else if (wr_en && cp0_reg_write_addr == ADDR_EPC) begin
                epc_reg <= cp0_reg_write;
            end
        end
    end
endmodule

// File: tb/tb_coprocessor_0.sv
// Randomized + directed bench for coprocessor_0 with a queue-based scoreboard
// fed by a behavioural model of the CP0 registers.
module tb_coprocessor_0;
    localparam logic [31:0] PRID = 32'h0001_8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall, cp0_reg_rw, exc_valid, exc_in_delay_slot, eret;
    logic [4:0]  cp0_reg_read_addr, cp0_reg_write_addr, exc_code;
    logic [31:0] cp0_reg_read, cp0_reg_write, exc_pc, exc_badvaddr;
    logic [31:0] epc, status, cause;
    logic [5:0]  hw_int;
    logic        timer_int, int_req;

    coprocessor_0 #(.DATA_WIDTH(32), .PRID(PRID)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .cp0_reg_rw(cp0_reg_rw),
        .cp0_reg_read_addr(cp0_reg_read_addr), .cp0_reg_read(cp0_reg_read),
        .cp0_reg_write_addr(cp0_reg_write_addr), .cp0_reg_write(cp0_reg_write),
        .hw_int(hw_int), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .exc_in_delay_slot(exc_in_delay_slot), .exc_badvaddr(exc_badvaddr), .eret(eret),
        .epc(epc), .status(status), .cause(cause), .timer_int(timer_int), .int_req(int_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        stall;
        logic [4:0]  raddr;
        logic [5:0]  hw;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        eret;
    } stim_t;

    typedef struct packed {
        logic [4:0]  raddr;
        logic [31:0] read;
        logic [31:0] epc;
        logic [31:0] status;
        logic [31:0] cause;
        logic        ti;
        logic        ir;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    // Behavioural CP0 state
    logic [31:0] m_count, m_compare, m_epc, m_badv, m_status;
    logic        m_bd, m_timer, m_half;
    logic [4:0]  m_excode;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;

    task automatic model_reset();
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0; m_badv = 0;
        m_status = 32'h0040_0000; m_bd = 0; m_timer = 0; m_half = 0;
        m_excode = 0; m_ip_sw = 0; m_ip_hw = 0;
    endtask

    function automatic logic [31:0] m_cause();
        logic ip7;
        ip7 = m_ip_hw[5] | m_timer;
        return (32'(m_bd) << 31) | (32'(m_timer) << 30) | (32'(ip7) << 15) |
               (32'(m_ip_hw[4:0]) << 10) | (32'(m_ip_sw) << 8) | (32'(m_excode) << 2);
    endfunction

    function automatic logic m_int_req();
        logic [31:0] c;
        c = m_cause();
        return (((c >> 8) & (m_status >> 8) & 32'hFF) != 0) && m_status[0] && !m_status[1];
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    // Effect of one rising edge with inputs s applied
    task automatic model_update(input stim_t s);
        logic        old_exl, wr, hit;
        logic [31:0] mask;
        old_exl = m_status[1];
        wr      = s.rw && !s.stall;
        hit     = (m_count == m_compare);
        if (wr && s.waddr == 5'd9) begin
            m_count = s.wdata; m_half = 0;
        end else begin
            if (m_half) m_count = m_count + 1;
            m_half = !m_half;
        end
        if (wr && s.waddr == 5'd11) begin
            m_compare = s.wdata; m_timer = 0;
        end else if (hit) m_timer = 1;
        if (wr && s.waddr == 5'd12) begin
            mask = 32'h0000_FF01 | ((s.exc || s.eret) ? 32'h0 : 32'h2);
            m_status = (m_status & ~mask) | (s.wdata & mask);
        end
        if (s.exc) m_status[1] = 1'b1;
        else if (s.eret) m_status[1] = 1'b0;
        if (wr && s.waddr == 5'd13) m_ip_sw = s.wdata[9:8];
        if (s.exc) begin
            m_excode = s.code;
            if (!old_exl) begin
                m_epc = s.ds ? s.pc - 4 : s.pc;
                m_bd  = s.ds;
            end
            if (s.code == 5'd4 || s.code == 5'd5) m_badv = s.bad;
        end else if (wr && s.waddr == 5'd14) m_epc = s.wdata;
        m_ip_hw = s.hw;
    endtask

    task automatic apply(input stim_t s);
        cp0_reg_rw = s.rw; cp0_reg_write_addr = s.waddr; cp0_reg_write = s.wdata;
        stall = s.stall; cp0_reg_read_addr = s.raddr; hw_int = s.hw;
        exc_valid = s.exc; exc_code = s.code; exc_pc = s.pc;
        exc_in_delay_slot = s.ds; exc_badvaddr = s.bad; eret = s.eret;
    endtask

    // Drive one cycle: expectation reflects state after the edge just taken.
    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.raddr = s.raddr; e.read = m_read(s.raddr); e.epc = m_epc; e.status = m_status;
        e.cause = m_cause(); e.ti = m_timer; e.ir = m_int_req();
        exp_q.push_back(e);
        model_update(s);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t rd(input logic [4:0] a);
        stim_t s;
        s = '0; s.raddr = a;
        return s;
    endfunction

    function automatic stim_t wr(input logic [4:0] a, input logic [31:0] d, input logic st);
        stim_t s;
        s = '0; s.rw = 1; s.waddr = a; s.wdata = d; s.stall = st;
        return s;
    endfunction

    function automatic stim_t ex(input logic [31:0] pc, input logic ds, input logic [4:0] code,
                                 input logic [31:0] bad, input logic x, input logic er);
        stim_t s;
        s = '0; s.exc = x; s.pc = pc; s.ds = ds; s.code = code; s.bad = bad; s.eret = er;
        return s;
    endfunction

    // Monitor: compare every presented cycle against the scoreboard head.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                txn++;
                chk("read", cp0_reg_read, mon_e.read);
                chk("epc", epc, mon_e.epc);
                chk("status", status, mon_e.status);
                chk("cause", cause, mon_e.cause);
                chk("timer_int", {31'b0, timer_int}, {31'b0, mon_e.ti});
                chk("int_req", {31'b0, int_req}, {31'b0, mon_e.ir});
                $display("txn %0d raddr=%0d read=%h status=%h cause=%h epc=%h ti=%b ir=%b",
                         txn, mon_e.raddr, cp0_reg_read, status, cause, epc, timer_int, int_req);
            end
        end
    end

    logic [4:0]  rd_addrs [7] = '{5'd8, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd20};
    logic [31:0] rd_vals  [7] = '{32'h0, 32'hFFFF_FFFF, 32'h0040_0000, 32'h0, 32'h0, PRID, 32'h0};
    logic [4:0]  pick     [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd20};

    initial begin
        stim_t s;
        int    n;
        apply('0);
        model_reset();
        #12 rst_n = 1'b1;
        model_update('0);

        // Reset values
        for (int i = 0; i < 7; i++) begin
            step(rd(rd_addrs[i]));
            #1 chk($sformatf("reset_read_%0d", rd_addrs[i]), cp0_reg_read, rd_vals[i]);
        end
        step(rd(5'd9));

        // Status write mask and stall suppression
        step(wr(5'd12, 32'hFFFF_FFFF, 1'b0));
        step(rd(5'd12));
        #1 chk("status_mask", cp0_reg_read, 32'h0040_FF03);
        step(wr(5'd12, 32'h0, 1'b1));
        step(rd(5'd12));
        #1 chk("status_stalled", status, 32'h0040_FF03);

        // Timer: Count from 0 reaches Compare=5 after 10 clocks, flag one edge later
        step(wr(5'd9, 32'h0, 1'b0));
        step(wr(5'd11, 32'd5, 1'b0));
        step(wr(5'd12, 32'h0000_8001, 1'b0));
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step(rd(5'd9));
            #1 if (timer_int) n = i;
        end
        chk("timer_latency", n, 10);
        chk("int_req_timer", {31'b0, int_req}, 32'd1);
        step(wr(5'd11, 32'hFFFF_FFFF, 1'b0));
        step(rd(5'd11));
        #1 chk("timer_clear", {30'b0, timer_int, int_req}, 32'd0);

        // Exception entry in a delay slot, then a nested one
        step(ex(32'h100, 1'b1, 5'd4, 32'h203, 1'b1, 1'b0));
        step(rd(5'd8));
        #1 begin
            chk("exc_epc", epc, 32'hFC);
            chk("exc_cause", cause, 32'h8000_0010);
            chk("exc_badvaddr", cp0_reg_read, 32'h203);
            chk("exc_exl_ireq", {30'b0, status[1], int_req}, 32'd2);
        end
        step(ex(32'h400, 1'b0, 5'd8, 32'h0, 1'b1, 1'b0));
        step(rd(5'd14));
        #1 begin
            chk("nested_epc", cp0_reg_read, 32'hFC);
            chk("nested_code", {27'b0, cause[6:2]}, 32'd8);
        end

        // Exception beats ERET in the same cycle
        step(ex(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1));
        step(rd(5'd12));
        #1 chk("eret_exl", {31'b0, status[1]}, 32'd0);
        step(ex(32'h500, 1'b0, 5'd10, 32'h0, 1'b1, 1'b1));
        step(rd(5'd12));
        #1 chk("exc_eret_exl", {31'b0, status[1]}, 32'd1);
        step(ex(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1));
        step(rd(5'd12));
        #1 chk("eret_alone_exl", {31'b0, status[1]}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            s = '0;
            s.rw    = ($urandom_range(0, 1) == 0);
            s.waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : pick[$urandom_range(0, 8)];
            s.wdata = $urandom;
            if (s.waddr == 5'd11 && $urandom_range(0, 1) == 0) s.wdata = m_count + $urandom_range(0, 4);
            if (s.waddr == 5'd9 && $urandom_range(0, 3) == 0) s.wdata = 32'hFFFF_FFFF - $urandom_range(0, 3);
            s.stall = ($urandom_range(0, 3) == 0);
            s.raddr = pick[$urandom_range(0, 8)];
            s.hw    = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h0;
            s.exc   = ($urandom_range(0, 9) == 0);
            s.code  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom);
            s.pc    = $urandom;
            s.ds    = 1'($urandom);
            s.bad   = $urandom;
            s.eret  = ($urandom_range(0, 9) == 0);
            step(s);
        end

        // Asynchronous reset mid-count with the timer flag set
        step(wr(5'd12, 32'h0000_8001, 1'b0));
        step(wr(5'd9, 32'd7, 1'b0));
        step(wr(5'd11, 32'd7, 1'b0));
        step(rd(5'd9));
        @(posedge clk);
        #2 chk("pre_reset_timer", {30'b0, timer_int, int_req}, 32'd3);
        rst_n = 1'b0;
        #1 begin
            chk("rst_status", status, 32'h0040_0000);
            chk("rst_cause", cause, 32'h0);
            chk("rst_epc", epc, 32'h0);
            chk("rst_count", cp0_reg_read, 32'h0);
            chk("rst_flags", {30'b0, timer_int, int_req}, 32'd0);
        end
        model_reset();
        apply('0);
        #1 rst_n = 1'b1;
        model_update('0);
        for (int i = 0; i < 6; i++) step(rd(5'd9));

        repeat (2) @(negedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coprocessor_0.md
# coprocessor_0

- Architectural CP0 register file and the responder side of the execution stage's CP0 move interface.
- MFC0 reads are served combinationally; MTC0 writes are committed on the clock edge.
- Also holds the Count/Compare timer and the interrupt-pending logic, and records exception entry and ERET.
- Sits beside the pipeline: EX drives the read/write ports (and does its own MEM/WB forwarding); the exception unit drives the exc_*/eret inputs.

## Interface
- DATA_WIDTH, 32, register width (only 32 is supported)
- PRID, 32'h0001_8000, constant value returned for PRId (reg 15)
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; while 1, suppresses the MTC0 write
- cp0_reg_rw  in  1  1 = write request (REG_WB), 0 = no write
- cp0_reg_read_addr  in  5  MFC0 source register number
- cp0_reg_read  out  32  combinational read data
- cp0_reg_write_addr  in  5  MTC0 destination register number
- cp0_reg_write  in  32  MTC0 write data
- hw_int  in  6  external interrupt lines, level-sensitive, mapped to IP[7:2]
- exc_valid  in  1  exception commit strobe, one cycle
- exc_code  in  5  ExcCode value for Cause[6:2]
- exc_pc  in  32  PC of the faulting instruction
- exc_in_delay_slot  in  1  faulting instruction is in a branch delay slot
- exc_badvaddr  in  32  faulting address (used only for codes 4 and 5)
- eret  in  1  ERET commit strobe, one cycle
- epc, status, cause  out  32 each  direct register views
- timer_int  out  1  sticky timer interrupt flag
- int_req  out  1  interrupt request to the exception unit

## Operation
Implemented registers and reset values:
- BadVAddr(8) = 0, read-only to software
- Count(9) = 0, writable
- Compare(11) = 32'hFFFF_FFFF
- Status(12) = 32'h0040_0000; write mask 32'h0000_FF03 (IM[15:8], EXL[1], IE[0]); BEV[22] reads 1
- Cause(13) = 0; write mask 32'h0000_0300 (IP[1:0] only)
- EPC(14) = 0, fully writable
- PRId(15) = PRID, constant
- Any other address reads 0; writes to it are ignored.

Cause fields:
- BD = bit 31, TI = bit 30
- IP[7:2] = bits 15:10; resampled from {hw_int[5] | timer_int, hw_int[4:0]} every cycle
- ExcCode = bits 6:2

Count:
- A one-bit phase toggle increments Count on every second clock (wraps at 32'hFFFF_FFFF -> 0).
- An MTC0 write to Count loads the value and clears the toggle.
- Count and the toggle keep running during stall.

timer_int:
- Set whenever Count == Compare at a clock edge.
- Cleared by any committed write to Compare; the clear wins over a same-cycle set.
- Drives TI and is ORed into IP[7].

int_req:
- int_req = |(Cause[15:8] & Status[15:8]) & Status.IE & ~Status.EXL.
- Combinational from register outputs only.

Update priority, highest first, when events coincide in one cycle:
1. exc_valid:
   - Cause.ExcCode <= exc_code; Status.EXL <= 1.
   - If the old EXL was 0: EPC <= exc_in_delay_slot ? exc_pc - 4 : exc_pc, and BD <= exc_in_delay_slot.
   - If the old EXL was 1: EPC and BD are unchanged.
   - If exc_code is 4 or 5: BadVAddr <= exc_badvaddr.
2. eret: Status.EXL <= 0.
3. MTC0, when cp0_reg_rw && !stall: apply the write mask.
   - A write is dropped only for the fields touched by the higher-priority event; for example, an MTC0 to Status.IM in the same cycle as an exception still lands.
   - Exception: an MTC0 to EPC in the same cycle as exc_valid is dropped entirely.

## Timing
- Reads are combinational, so cp0_reg_read reflects pre-edge state.
- A same-cycle write is not visible on the read port (EX forwards it).
- Writes are visible on cp0_reg_read and on the direct outputs one cycle after the committing edge.
- timer_int rises one edge after Count == Compare; int_req follows combinationally.
- Reset is asynchronous and takes effect mid-operation: every register returns to its reset value, and timer_int, int_req and the toggle drop to 0 immediately.

## Test plan
- Reset, then read regs 8, 9, 11, 12, 13, 14, 15, 20 -> 0, 0, FFFF_FFFF, 0040_0000, 0, 0, PRID, 0.
- MTC0 Status = FFFF_FFFF -> reads 0040_FF03; same write with stall=1 -> Status unchanged.
- Write Compare = 5, Count = 0, Status = 0000_8001 -> Count reaches 5 after 10 clocks; timer_int = 1 and int_req = 1 one edge later; write Compare -> both clear next cycle.
- exc_valid with exc_pc = 0x100, delay slot = 1, code 4, badvaddr = 0x203 -> EPC = 0xFC, Cause = 0x8000_0010, BadVAddr = 0x203, EXL = 1, int_req = 0.
- Second exc_valid while EXL = 1 (pc = 0x400) -> EPC stays 0xFC, ExcCode updated.
- exc_valid and eret in the same cycle -> EXL = 1; then eret alone -> EXL = 0.
- Assert rst_n low mid-count -> all outputs at reset values before the next edge.
